m_mux_scan: RTL and testbench
=============================

Name: m_mux_scan

Overview:
- Parametrised, registered successor to the combinational 1-of-N bit-select mux in the MPU datapath.
- Generalised to WORD lines with any select width MUX.
- Two operating modes:
  - Direct: single select request, one output beat.
  - Scan: a sequencer walks all WORD lines and emits one bit per beat.
- Output is a valid/ready stream, so MPU control/debug logic can consume it with backpressure.
- A WORD-bit snapshot of the scanned lines is captured at the end of each scan.

Parameters:
- WORD, 8, number of input lines; must be >= 2.
- MUX, 3, select/index width; must satisfy 2^MUX >= WORD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- line  input  WORD  input lines; bit i is channel i.
- select  input  MUX  direct-mode channel index.
- sel_valid  input  1  direct-mode request strobe.
- scan_start  input  1  scan request strobe.
- o_ready  input  1  downstream accepts the current beat.
- o  output  1  registered selected bit.
- o_valid  output  1  beat valid; held until accepted.
- o_sel  output  MUX  index of the channel in o.
- o_err  output  1  beat carries an out-of-range select.
- busy  output  1  high whenever the FSM is not IDLE.
- snapshot  output  WORD  bits captured by the last completed scan.
- scan_done  output  1  one-cycle pulse when a scan completes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - FSM goes to IDLE and the index counter idx clears to 0.
  - o, o_valid, o_sel, o_err, busy, snapshot and scan_done all clear to 0.
  - Reset mid-scan aborts the scan: no scan_done, snapshot cleared, any pending beat dropped.
- Slot-free condition: slot_free = !o_valid || o_ready. A new beat is loaded only when slot_free is true.
- Beat hold rule:
  - While o_valid=1 and o_ready=0, o, o_sel and o_err hold stable.
  - On a cycle with o_valid=1 and o_ready=1, o_valid drops to 0 next cycle unless a new beat loads in the same cycle.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - scan_start=1 and slot_free: go to SCAN and set idx=0. No beat is loaded this cycle.
  - Otherwise, sel_valid=1 and slot_free (direct request): next cycle o_valid=1, o_sel=select.
    - select < WORD: o=line[select], o_err=0.
    - select >= WORD: o=0, o_err=1.
  - Direct latency is 1 cycle, request to o_valid.
  - If scan_start and sel_valid are both high, scan_start wins and the direct request is dropped.
  - Requests made while the slot is not free are dropped; the requester must re-issue.
- SCAN:
  - Each slot_free cycle loads o=line[idx], o_sel=idx, o_err=0, o_valid=1, and captures scan_shadow[idx]=line[idx].
  - If idx==WORD-1, go to DONE; otherwise idx increments by 1.
  - Lines are sampled at beat-load time, not at scan start.
  - sel_valid and scan_start are ignored while in SCAN.
- DONE:
  - Waits for the final beat handshake (o_valid && o_ready).
  - On that cycle: snapshot <= scan_shadow, scan_done=1 for exactly the next cycle, FSM returns to IDLE.
  - busy is low from that next cycle.
  - IDLE requests are accepted starting the cycle after DONE exits.
- Throughput:
  - With o_ready held at 1, scan start at cycle N gives beats at cycles N+2 .. N+WORD+1.
  - scan_done follows at cycle N+WORD+2.
- Width rules:
  - idx is MUX bits and never exceeds WORD-1; there is no wrap within a scan.
  - snapshot bit i equals channel i.

Test Plan:
- Reset/direct, WORD=8, MUX=3: after reset, all outputs are 0. line=8'b1010_0110, select=3'd2, sel_valid pulse at cycle N, o_ready=1 -> cycle N+1 has o_valid=1, o=1, o_sel=2, o_err=0; next cycle o_valid=0.
- Out of range, WORD=6, MUX=3: select=3'd7 -> o=0, o_err=1, o_sel=7, single beat.
- Full scan: line=8'hC5, o_ready=1, scan_start at N ->
  - beats at N+2..N+9 carry o_sel 0..7 with o = 1,0,1,0,0,0,1,1;
  - scan_done=1 at N+10 only; snapshot=8'hC5; busy low at N+10.
- Backpressure: o_ready=0 for 3 cycles during beat idx=3 -> o, o_sel=3 and o_valid held stable; no skipped or duplicated index; snapshot still correct.
- Simultaneous/ignored: scan_start and sel_valid in the same IDLE cycle -> scan runs and no direct beat is produced. sel_valid during SCAN -> no extra beat.
- Reset mid-scan: assert rst when idx=4 -> next cycle o_valid=0, busy=0, snapshot=0, and no scan_done pulse ever occurs.

Source files
------------

// File: rtl/m_mux_scan.sv
// Registered 1-of-WORD bit-select with a valid/ready output stream and a scan
// sequencer that walks every line, emitting one bit per beat and a final snapshot.
module m_mux_scan #(
  parameter int WORD = 8,
  parameter int MUX  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] line,
  input  logic [MUX-1:0]  select,
  input  logic            sel_valid,
  input  logic            scan_start,
  input  logic            o_ready,
  output logic            o,
  output logic            o_valid,
  output logic [MUX-1:0]  o_sel,
  output logic            o_err,
  output logic            busy,
  output logic [WORD-1:0] snapshot,
  output logic            scan_done
);

  localparam int            NLINE    = 1 << MUX;
  localparam logic [MUX:0]  WORD_L   = (MUX+1)'(WORD);
  localparam logic [MUX-1:0] LAST_IDX = MUX'(WORD - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q;
  logic [MUX-1:0]  idx_q;
  logic            o_q;
  logic            o_valid_q;
  logic [MUX-1:0]  o_sel_q;
  logic            o_err_q;
  logic [WORD-1:0] shadow_q;
  logic [WORD-1:0] snapshot_q;
  logic            scan_done_q;

  logic [NLINE-1:0] line_ext;
  logic             slot_free;
  logic             sel_oor;

  // Pad the lines up to the full select range so any index reads a defined 0.
  for (genvar gi = 0; gi < NLINE; gi++) begin : g_ext
    if (gi < WORD) begin : g_in
      assign line_ext[gi] = line[gi];
    end else begin : g_pad
      assign line_ext[gi] = 1'b0;
    end
  end

  assign slot_free = !o_valid_q || o_ready;
  assign sel_oor   = {1'b0, select} >= WORD_L;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      o_q         <= 1'b0;
      o_valid_q   <= 1'b0;
      o_sel_q     <= '0;
      o_err_q     <= 1'b0;
      shadow_q    <= '0;
      snapshot_q  <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (o_valid_q && o_ready) begin
        o_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (scan_start && slot_free) begin
            state_q <= SCAN;
            idx_q   <= '0;
          end else if (sel_valid && slot_free) begin
            o_valid_q <= 1'b1;
            o_sel_q   <= select;
            o_err_q   <= sel_oor;
            o_q       <= sel_oor ? 1'b0 : line_ext[select];
          end
        end
        SCAN: begin
          if (slot_free) begin
            o_valid_q        <= 1'b1;
            o_sel_q          <= idx_q;
            o_err_q          <= 1'b0;
            o_q              <= line_ext[idx_q];
            shadow_q[idx_q]  <= line_ext[idx_q];
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          // The scan only completes once its final beat has been consumed.
          if (o_valid_q && o_ready) begin
            snapshot_q  <= shadow_q;
            scan_done_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o         = o_q;
  assign o_valid   = o_valid_q;
  assign o_sel     = o_sel_q;
  assign o_err     = o_err_q;
  assign busy      = (state_q != IDLE);
  assign snapshot  = snapshot_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_m_mux_scan.sv
// Scoreboard bench for m_mux_scan: stimulus pushes expected beats and snapshots,
// a negedge monitor pops and compares on every handshake and scan_done pulse.
module tb_m_mux_scan;

  logic       clk;
  logic       rst;
  logic [7:0] line;
  logic [2:0] select;
  logic       sel_valid;
  logic       scan_start;
  logic       o_ready;
  logic       o;
  logic       o_valid;
  logic [2:0] o_sel;
  logic       o_err;
  logic       busy;
  logic [7:0] snapshot;
  logic       scan_done;

  logic [5:0] line6;
  logic [2:0] select6;
  logic       sel_valid6;
  logic       scan_start6;
  logic       o_ready6;
  logic       o6;
  logic       o_valid6;
  logic [2:0] o_sel6;
  logic       o_err6;
  logic       busy6;
  logic [5:0] snapshot6;
  logic       scan_done6;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       b;
    logic [2:0] sel;
    logic       err;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] snap_q[$];

  m_mux_scan #(.WORD(8), .MUX(3)) u_dut (
    .clk(clk), .rst(rst), .line(line), .select(select), .sel_valid(sel_valid),
    .scan_start(scan_start), .o_ready(o_ready), .o(o), .o_valid(o_valid),
    .o_sel(o_sel), .o_err(o_err), .busy(busy), .snapshot(snapshot), .scan_done(scan_done)
  );

  m_mux_scan #(.WORD(6), .MUX(3)) u_dut6 (
    .clk(clk), .rst(rst), .line(line6), .select(select6), .sel_valid(sel_valid6),
    .scan_start(scan_start6), .o_ready(o_ready6), .o(o6), .o_valid(o_valid6),
    .o_sel(o_sel6), .o_err(o_err6), .busy(busy6), .snapshot(snapshot6), .scan_done(scan_done6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_scan(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{b: v[i], sel: 3'(i), err: 1'b0});
    end
  endtask

  task automatic wait_sel(input logic [2:0] s);
    int n;
    n = 0;
    while (!(o_valid === 1'b1 && o_sel == s) && n < 50) begin
      tick();
      n++;
    end
    chk("wait_sel_timeout", 32'(n < 50), 32'd1);
  endtask

  task automatic wait_done(input logic [7:0] snap);
    int n;
    n = 0;
    while (scan_done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("wait_done_timeout", 32'(n < 60), 32'd1);
    chk("done_snapshot", 32'(snapshot), 32'(snap));
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: scoreboard pops, hold-stability and snapshot checks.
  logic       stall_prev = 1'b0;
  logic [4:0] prev_beat  = '0;
  always @(negedge clk) begin
    beat_t e;
    logic [7:0] s;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_beat", 32'({o, o_sel, o_err}), 32'(prev_beat));
      end
      if (o_valid === 1'b1 && o_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_extra actual o=%0b o_sel=%0d o_err=%0b required none", o, o_sel, o_err);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({o, o_sel, o_err}), 32'({e.b, e.sel, e.err}));
        end
      end
      if (scan_done === 1'b1) begin
        if (snap_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scan_done_extra actual=1 required=0");
        end else begin
          s = snap_q.pop_front();
          chk("snapshot", 32'(snapshot), 32'(s));
        end
      end
      stall_prev = (o_valid === 1'b1) && !o_ready;
      prev_beat  = {o, o_sel, o_err};
    end
  end

  logic [2:0] dir_sel [4] = '{3'd2, 3'd0, 3'd7, 3'd5};
  logic       dir_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [2:0] sel6_v  [3] = '{3'd7, 3'd5, 3'd6};
  logic       o6_exp  [3] = '{1'b0, 1'b1, 1'b0};
  logic       err6_exp[3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; line = '0; select = '0; sel_valid = 1'b0; scan_start = 1'b0; o_ready = 1'b1;
    line6 = 6'b10_1100; select6 = '0; sel_valid6 = 1'b0; scan_start6 = 1'b0; o_ready6 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_outs", 32'({o, o_sel, o_err, busy, scan_done}), 32'd0);
    chk("rst_snapshot", 32'(snapshot), 32'd0);
    chk("rst_o_valid6", 32'(o_valid6), 32'd0);

    // Direct selects on line = 1010_0110
    line = 8'b1010_0110;
    for (int i = 0; i < 4; i++) begin
      select = dir_sel[i];
      sel_valid = 1'b1;
      exp_q.push_back('{b: dir_exp[i], sel: dir_sel[i], err: 1'b0});
      tick();
      sel_valid = 1'b0;
      chk("direct_valid", 32'(o_valid), 32'd1);
      chk("direct_o", 32'(o), 32'(dir_exp[i]));
      tick();
      chk("direct_drop", 32'(o_valid), 32'd0);
    end

    // WORD=6 instance: out-of-range and boundary selects
    for (int i = 0; i < 3; i++) begin
      select6 = sel6_v[i];
      sel_valid6 = 1'b1;
      tick();
      sel_valid6 = 1'b0;
      chk("w6_valid", 32'(o_valid6), 32'd1);
      chk("w6_beat", 32'({o6, o_sel6, o_err6}), 32'({o6_exp[i], sel6_v[i], err6_exp[i]}));
      tick();
      chk("w6_drop", 32'(o_valid6), 32'd0);
    end

    // Full scan with cycle-exact timing, line = C5
    line = 8'hC5;
    push_scan(8'hC5, 8);
    snap_q.push_back(8'hC5);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    chk("scan_n1_valid", 32'(o_valid), 32'd0);
    chk("scan_n1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("scan_beat_valid", 32'(o_valid), 32'd1);
      chk("scan_beat_sel", 32'(o_sel), 32'(i));
    end
    tick();
    chk("scan_done_pulse", 32'(scan_done), 32'd1);
    chk("scan_done_busy", 32'(busy), 32'd0);
    chk("scan_done_valid", 32'(o_valid), 32'd0);
    tick();
    chk("scan_done_once", 32'(scan_done), 32'd0);

    // Backpressure on beat 3, lines disturbed while stalled
    line = 8'h3A;
    push_scan(8'h3A, 8);
    snap_q.push_back(8'h3A);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    wait_sel(3'd3);
    o_ready = 1'b0;
    line = 8'h00;
    repeat (3) begin
      tick();
      chk("bp_sel", 32'(o_sel), 32'd3);
    end
    o_ready = 1'b1;
    line = 8'h3A;
    wait_done(8'h3A);

    // Simultaneous start/select, then sel_valid during the scan
    tick();
    line = 8'h0F;
    select = 3'd1;
    sel_valid = 1'b1;
    scan_start = 1'b1;
    push_scan(8'h0F, 8);
    snap_q.push_back(8'h0F);
    tick();
    scan_start = 1'b0;
    select = 3'd5;
    wait_done(8'h0F);
    sel_valid = 1'b0;

    // Reset mid-scan when idx is 4 (beat 3 on the output)
    tick();
    line = 8'hFF;
    push_scan(8'hFF, 3);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    wait_sel(3'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_snapshot", 32'(snapshot), 32'd0);
    repeat (15) tick();

    chk("beats_left", 32'(exp_q.size()), 32'd0);
    chk("snaps_left", 32'(snap_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
